// File: rtl/ov7670_capture.sv
// OV7670 QVGA RGB444 capture: byte pairs -> 12-bit pixels with a linear frame-buffer write address.
// Define CAPTURE_STATS_EN to add per-frame statistics outputs (frame_cnt, last_lines, last_pixels, geom_err).
module ov7670_capture #(
    parameter int unsigned H_RES  = 320,
    parameter int unsigned V_RES  = 240,
    parameter int unsigned ADDR_W = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        d,
    output logic              we,
    output logic [ADDR_W-1:0] wAddr,
    output logic [11:0]       wData,
    output logic              busy,
    output logic              frame_done,
    output logic              overflow
`ifdef CAPTURE_STATS_EN
    ,
    output logic [15:0]       frame_cnt,
    output logic [8:0]        last_lines,
    output logic [ADDR_W-1:0] last_pixels,
    output logic              geom_err
`endif
);

    localparam int unsigned     TotalPix  = H_RES * V_RES;
    localparam logic [ADDR_W:0] PIX_TOTAL = TotalPix[ADDR_W:0];

    typedef enum logic [1:0] {StIdle, StSync, StArm, StCapture} state_e;

    state_e            r_state;
    logic              r_vsync_q, r_vsync_qq, r_href_q, r_href_qq;
    logic [7:0]        r_d_q;
    logic              r_phase;
    logic [3:0]        r_red;
    logic [ADDR_W:0]   r_pix_cnt;
    logic              r_we, r_busy, r_frame_done, r_overflow;
    logic [ADDR_W-1:0] r_waddr;
    logic [11:0]       r_wdata;

    logic w_vs_rise, w_vs_fall, w_href_fall, w_capture, w_pix_ready, w_room, w_wr;

    assign w_vs_rise   = r_vsync_q & ~r_vsync_qq;
    assign w_vs_fall   = ~r_vsync_q & r_vsync_qq;
    assign w_href_fall = ~r_href_q & r_href_qq;
    assign w_capture   = (r_state == StCapture);
    assign w_pix_ready = w_capture & r_href_q & r_phase;
    assign w_room      = (r_pix_cnt < PIX_TOTAL);
    assign w_wr        = w_pix_ready & w_room;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= StIdle;
            r_vsync_q    <= 1'b0;
            r_vsync_qq   <= 1'b0;
            r_href_q     <= 1'b0;
            r_href_qq    <= 1'b0;
            r_d_q        <= '0;
            r_phase      <= 1'b0;
            r_red        <= '0;
            r_pix_cnt    <= '0;
            r_we         <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
            r_waddr      <= '0;
            r_wdata      <= '0;
        end else begin
            r_vsync_q    <= vsync;
            r_vsync_qq   <= r_vsync_q;
            r_href_q     <= href;
            r_href_qq    <= r_href_q;
            r_d_q        <= d;
            r_we         <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (enable) r_state <= StSync;
                end
                StSync: begin
                    if (!enable)        r_state <= StIdle;
                    else if (w_vs_rise) r_state <= StArm;
                end
                StArm: begin
                    if (!enable) begin
                        r_state <= StIdle;
                    end else if (w_vs_fall) begin
                        r_state   <= StCapture;
                        r_busy    <= 1'b1;
                        r_pix_cnt <= '0;
                        r_phase   <= 1'b0;
                        r_waddr   <= '0;
                    end
                end
                StCapture: begin
                    if (r_href_q) begin
                        r_phase <= ~r_phase;
                        if (!r_phase) r_red <= r_d_q[3:0];
                    end else if (w_href_fall) begin
                        // An odd trailing byte is discarded here.
                        r_phase <= 1'b0;
                    end
                    if (w_wr) begin
                        r_we      <= 1'b1;
                        r_wdata   <= {r_red, r_d_q};
                        r_waddr   <= r_pix_cnt[ADDR_W-1:0];
                        r_pix_cnt <= r_pix_cnt + 1'b1;
                    end else if (w_pix_ready) begin
                        r_overflow <= 1'b1;
                    end
                    // The frame always completes; enable only picks the next state.
                    if (w_vs_rise) begin
                        r_frame_done <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= enable ? StArm : StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign we         = r_we;
    assign wAddr      = r_waddr;
    assign wData      = r_wdata;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign overflow   = r_overflow;

`ifdef CAPTURE_STATS_EN
    localparam logic [8:0] LINES_EXP = V_RES[8:0];

    logic [8:0]        r_line_cnt, r_last_lines;
    logic [15:0]       r_frame_cnt;
    logic [ADDR_W-1:0] r_last_pixels;
    logic              r_geom_err;
    logic              w_arm_go;
    logic [8:0]        w_lines_now;
    logic [ADDR_W:0]   w_pix_now;

    assign w_arm_go    = (r_state == StArm) && enable && w_vs_fall;
    assign w_lines_now = r_line_cnt + {8'd0, w_capture & w_href_fall};
    assign w_pix_now   = r_pix_cnt + {{ADDR_W{1'b0}}, w_wr};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_line_cnt    <= '0;
            r_last_lines  <= '0;
            r_frame_cnt   <= '0;
            r_last_pixels <= '0;
            r_geom_err    <= 1'b0;
        end else begin
            if (w_arm_go)                       r_line_cnt <= '0;
            else if (w_capture && w_href_fall) r_line_cnt <= w_lines_now;
            // Latch alongside frame_done, including a write landing in the same cycle.
            if (w_capture && w_vs_rise) begin
                r_frame_cnt   <= r_frame_cnt + 16'd1;
                r_last_lines  <= w_lines_now;
                r_last_pixels <= w_pix_now[ADDR_W-1:0];
                if (w_lines_now != LINES_EXP || w_pix_now != PIX_TOTAL) r_geom_err <= 1'b1;
            end
        end
    end

    assign frame_cnt   = r_frame_cnt;
    assign last_lines  = r_last_lines;
    assign last_pixels = r_last_pixels;
    assign geom_err    = r_geom_err;
`endif

endmodule

// File: tb/tb_ov7670_capture.sv
// Directed bench for ov7670_capture on a reduced 8x6 frame; CAPTURE_STATS_EN adds statistics checks.
module tb_ov7670_capture;

    localparam int unsigned H     = 8;
    localparam int unsigned V     = 6;
    localparam int unsigned AW    = 6;
    localparam int unsigned TOTAL = H * V;

    logic          clk = 1'b0;
    logic          reset, enable, vsync, href;
    logic [7:0]    d;
    logic          we, busy, frame_done, overflow;
    logic [AW-1:0] wAddr;
    logic [11:0]   wData;
`ifdef CAPTURE_STATS_EN
    logic [15:0]   frame_cnt;
    logic [8:0]    last_lines;
    logic [AW-1:0] last_pixels;
    logic          geom_err;
`endif

    ov7670_capture #(.H_RES(H), .V_RES(V), .ADDR_W(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .vsync      (vsync),
        .href       (href),
        .d          (d),
        .we         (we),
        .wAddr      (wAddr),
        .wData      (wData),
        .busy       (busy),
        .frame_done (frame_done),
        .overflow   (overflow)
`ifdef CAPTURE_STATS_EN
        ,
        .frame_cnt  (frame_cnt),
        .last_lines (last_lines),
        .last_pixels(last_pixels),
        .geom_err   (geom_err)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_total = 0;
    int n_bad   = 0;
    int wr_cnt = 0, fd_cnt = 0, exp_addr = 0, last_addr = 0, t_b1 = 0;
    bit expect_wr = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Pixel value at linear index a; pixel 0 gives bytes 0x0A, 0x5C.
    function automatic logic [11:0] pix_val(input int unsigned a);
        logic [31:0] t;
        t = 32'hA5C + a * 32'h1F3;
        return t[11:0];
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (frame_done) fd_cnt++;
            if (we) begin
                wr_cnt++;
                last_addr = int'(wAddr);
                if (expect_wr) begin
                    check_eq("we_in_range", 32'(exp_addr < int'(TOTAL)), 32'd1);
                    check_eq("waddr", 32'(wAddr), exp_addr);
                    check_eq("wdata", 32'(wData), 32'(pix_val(exp_addr)));
                    if (exp_addr == 0) check_eq("latency_pix0", cyc - t_b1, 32'd2);
                    exp_addr++;
                end else begin
                    check_eq("we_unexpected", 32'(we), 32'd0);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            href = 1'b0;
            d    = 8'hE7;
        end
    endtask

    task automatic send_bytes(input int line, input int b_from, input int b_to);
        for (int b = b_from; b < b_to; b++) begin
            int unsigned p;
            logic [11:0] v;
            logic [31:0] pw;
            p  = line * H + b / 2;
            v  = pix_val(p);
            pw = p;
            @(negedge clk);
            href = 1'b1;
            d    = (b % 2 == 0) ? {pw[3:0], v[11:8]} : v[7:0];
            if (b % 2 == 1 && p == 0) t_b1 = cyc;
        end
    endtask

    task automatic send_line(input int line, input int nbytes);
        send_bytes(line, 0, nbytes);
        idle(4);
    endtask

    task automatic vblank();
        repeat (6) begin
            @(negedge clk);
            vsync = 1'b1;
            href  = 1'b0;
        end
        @(negedge clk);
        vsync = 1'b0;
        idle(3);
    endtask

    task automatic run_frame(input int nlines, input int long_line, input bit exp_wr);
        expect_wr = exp_wr;
        exp_addr  = 0;
        wr_cnt    = 0;
        fd_cnt    = 0;
        for (int l = 0; l < nlines; l++) send_line(l, (l == long_line) ? 2 * H + 1 : 2 * H);
        vblank();
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_we"}, 32'(we), 32'd0);
        check_eq({tag, "_waddr"}, 32'(wAddr), 32'd0);
        check_eq({tag, "_wdata"}, 32'(wData), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        check_eq({tag, "_overflow"}, 32'(overflow), 32'd0);
`ifdef CAPTURE_STATS_EN
        check_eq({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
        check_eq({tag, "_last_lines"}, 32'(last_lines), 32'd0);
        check_eq({tag, "_last_pixels"}, 32'(last_pixels), 32'd0);
        check_eq({tag, "_geom_err"}, 32'(geom_err), 32'd0);
`endif
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        vsync  = 1'b0;
        href   = 1'b0;
        d      = 8'h00;
        repeat (3) @(negedge clk);
        check_all_zero("reset");

        // Enable mid-frame: the partial frame must not be written.
        reset  = 1'b0;
        enable = 1'b1;
        run_frame(3, -1, 1'b0);
        check_eq("partial_writes", wr_cnt, 32'd0);
        check_eq("partial_frame_done", fd_cnt, 32'd0);
        check_eq("armed_busy", 32'(busy), 32'd1);

        run_frame(V, -1, 1'b1);
        check_eq("full_writes", wr_cnt, TOTAL);
        check_eq("full_frame_done", fd_cnt, 32'd1);
        check_eq("full_last_addr", last_addr, TOTAL - 1);
        check_eq("full_overflow", 32'(overflow), 32'd0);
        check_eq("full_busy_next", 32'(busy), 32'd1);

        // First line carries one extra trailing byte.
        run_frame(V, 0, 1'b1);
        check_eq("oddline_writes", wr_cnt, TOTAL);
        check_eq("oddline_frame_done", fd_cnt, 32'd1);
        check_eq("oddline_overflow", 32'(overflow), 32'd0);

        // One line too many.
        run_frame(V + 1, -1, 1'b1);
        check_eq("ovf_writes", wr_cnt, TOTAL);
        check_eq("ovf_last_addr", last_addr, TOTAL - 1);
        check_eq("ovf_flag", 32'(overflow), 32'd1);
        check_eq("ovf_frame_done", fd_cnt, 32'd1);

        run_frame(V, -1, 1'b1);
        check_eq("post_ovf_writes", wr_cnt, TOTAL);
        check_eq("ovf_sticky", 32'(overflow), 32'd1);

        // Drop enable mid-frame: the frame still completes, then nothing more.
        expect_wr = 1'b1;
        exp_addr  = 0;
        wr_cnt    = 0;
        fd_cnt    = 0;
        for (int l = 0; l < 3; l++) send_line(l, 2 * H);
        enable = 1'b0;
        for (int l = 3; l < V; l++) send_line(l, 2 * H);
        vblank();
        check_eq("dis_writes", wr_cnt, TOTAL);
        check_eq("dis_frame_done", fd_cnt, 32'd1);
        check_eq("dis_busy", 32'(busy), 32'd0);
        run_frame(V, -1, 1'b0);
        check_eq("dis_next_writes", wr_cnt, 32'd0);
        check_eq("dis_next_frame_done", fd_cnt, 32'd0);
        check_eq("dis_next_busy", 32'(busy), 32'd0);

        // Reset in the middle of the second line.
        enable = 1'b1;
        idle(2);
        vblank();
        expect_wr = 1'b1;
        exp_addr  = 0;
        wr_cnt    = 0;
        fd_cnt    = 0;
        send_line(0, 2 * H);
        send_bytes(1, 0, 5);
        @(negedge clk);
        reset = 1'b1;
        href  = 1'b1;
        d     = 8'hE7;
        @(negedge clk);
        check_eq("rst_mid_writes", wr_cnt, 32'(H + 2));
        check_all_zero("rst_mid");
        expect_wr = 1'b0;
        wr_cnt    = 0;
        @(negedge clk);
        reset = 1'b0;
        send_bytes(1, 6, 2 * H);
        idle(4);
        for (int l = 2; l < V; l++) send_line(l, 2 * H);
        check_eq("rst_after_writes", wr_cnt, 32'd0);
        vblank();
        check_eq("rst_after_frame_done", fd_cnt, 32'd0);

        // Three good frames, then a short one.
        @(negedge clk);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        check_eq("rst2_overflow", 32'(overflow), 32'd0);
        idle(2);
        vblank();
        for (int f = 0; f < 3; f++) begin
            run_frame(V, -1, 1'b1);
            check_eq("good_writes", wr_cnt, TOTAL);
            check_eq("good_frame_done", fd_cnt, 32'd1);
        end
`ifdef CAPTURE_STATS_EN
        check_eq("stats_frame_cnt", 32'(frame_cnt), 32'd3);
        check_eq("stats_last_lines", 32'(last_lines), V);
        check_eq("stats_last_pixels", 32'(last_pixels), TOTAL);
        check_eq("stats_geom_err", 32'(geom_err), 32'd0);
`endif
        run_frame(V - 1, -1, 1'b1);
        check_eq("short_writes", wr_cnt, TOTAL - H);
        check_eq("short_frame_done", fd_cnt, 32'd1);
`ifdef CAPTURE_STATS_EN
        check_eq("short_frame_cnt", 32'(frame_cnt), 32'd4);
        check_eq("short_last_lines", 32'(last_lines), V - 1);
        check_eq("short_last_pixels", 32'(last_pixels), TOTAL - H);
        check_eq("short_geom_err", 32'(geom_err), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
